fp_mul_arbiter: RTL and testbench

- Shares one fp_multiplier instance (combinational, 32-bit single-precision, a*b -> result) among NUM_REQ requesters.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- Operands are registered, multiplied, and the result is registered with the requester ID.
- Two-stage pipeline with full backpressure; sits between the accelerator's compute lanes and the shared multiplier.

---
 rtl/fp_mul_arbiter.sv | 129 ++++++++++++
 tb/tb_fp_mul_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that shares one combinational single-precision multiplier
// among NUM_REQ requesters through a two-stage (operand, result) pipeline.
module fp_multiplier (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  logic [47:0] prod_s;
  logic [9:0]  exp_s;

  // Truncating mantissa product; exponent wraps modulo 256, no special values.
  always_comb begin
    prod_s = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};
    exp_s  = {2'b00, a_i[30:23]} + {2'b00, b_i[30:23]} - 10'd127 + {9'd0, prod_s[47]};
    p_o    = {a_i[31] ^ b_i[31], exp_s[7:0], (prod_s[47] ? prod_s[46:24] : prod_s[45:23])};
  end
endmodule

module fp_mul_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [CNT_W-1:0]      ops_done,
  output logic                  busy
);
  logic              s1_valid_q;
  logic [31:0]       s1_a_q, s1_b_q;
  logic [ID_W-1:0]   s1_id_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  ops_q;

  logic              s2_load_s, s1_free_s, accept_s, found_s, drain_s;
  logic [ID_W-1:0]   grant_s, idx_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [31:0]       prod_s;

  fp_multiplier u_mul (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (prod_s)
  );

  // Pipeline advance conditions.
  always_comb begin
    s2_load_s = s1_valid_q & (~rsp_valid_q | rsp_ready);
    s1_free_s = ~s1_valid_q | s2_load_s;
    drain_s   = rsp_valid_q & rsp_ready;
  end

  // Round-robin search from rr_q; grant is suppressed while in reset or when S1 cannot take a new op.
  always_comb begin
    found_s = 1'b0;
    grant_s = '0;
    idx_s   = '0;
    ready_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s = 1'b1;
        grant_s = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    if (rst_n && s1_free_s && found_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
    accept_s = |ready_s;
    rr_d     = (int'(grant_s) == NUM_REQ - 1) ? '0 : grant_s + ID_W'(1);
  end

  // Operand stage, result stage, pointer and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= 32'd0;
      s1_b_q      <= 32'd0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_id_q    <= '0;
      rr_q        <= '0;
      ops_q       <= '0;
    end else begin
      if (accept_s) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= req_a[32*int'(grant_s) +: 32];
        s1_b_q     <= req_b[32*int'(grant_s) +: 32];
        s1_id_q    <= grant_s;
        rr_q       <= rr_d;
      end else if (s2_load_s) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load_s) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= prod_s;
        rsp_id_q    <= s1_id_q;
      end else if (drain_s) begin
        rsp_valid_q <= 1'b0;
      end
      if (drain_s) begin
        ops_q <= ops_q + CNT_W'(1);
      end
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign ops_done  = ops_q;
  assign busy      = s1_valid_q | rsp_valid_q;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: queue-based reference model checked every cycle, plus
// a vector table and directed sequences for arbitration, backpressure and reset.
module tb_fp_mul_arbiter;
  localparam int N = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic [CW-1:0] ops_done;
  logic          busy;

  fp_mul_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .ops_done(ops_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int id; bit in_s2; } op_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] p; } vec_t;

  op_t q[$];
  int  m_rr, m_ops, m_grant;
  bit  m_acc;
  int  n_tests = 0, n_fail = 0;
  logic [N-1:0] obs_ready;
  logic obs_rv, obs_busy;
  logic [31:0] obs_data;
  logic [1:0] obs_id;
  logic [CW-1:0] obs_ops;

  // Product from the IEEE field definitions with plain integer arithmetic.
  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
    longint ma, mb, p;
    int e;
    ma = longint'(a[22:0]) + 64'sd8388608;
    mb = longint'(b[22:0]) + 64'sd8388608;
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p >= (64'sd1 <<< 47)) begin p = p >>> 24; e = e + 1; end
    else p = p >>> 23;
    return {a[31] ^ b[31], 8'(e), 23'(p)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: compare at negedge against the model, then advance the model at posedge.
  task automatic cycle(bit check);
    bit rv, s1_full, adv, free, drain;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    rv      = (q.size() > 0) && q[0].in_s2;
    s1_full = (q.size() == 2) || (q.size() == 1 && !q[0].in_s2);
    adv     = s1_full && (!rv || rsp_ready);
    free    = !s1_full || adv;
    drain   = rv && rsp_ready;
    m_grant = -1;
    for (int k = 0; k < N; k++)
      if (m_grant < 0 && req_valid[(m_rr + k) % N]) m_grant = (m_rr + k) % N;
    m_acc = rst_n && free && (m_grant >= 0);
    exp_ready = m_acc ? N'(1 << m_grant) : '0;
    obs_ready = req_ready; obs_rv = rsp_valid; obs_busy = busy;
    obs_data = rsp_data; obs_id = rsp_id; obs_ops = ops_done;
    if (check) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(rv));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("ops_done", 32'(ops_done), 32'(m_ops % (1 << CW)));
      if (rv) begin
        chk("rsp_data", rsp_data, q[0].data);
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_rr = 0; m_ops = 0;
    end else begin
      if (drain) begin void'(q.pop_front()); m_ops++; end
      if (adv) q[q.size()-1].in_s2 = 1'b1;
      if (m_acc) begin
        q.push_back('{ref_mul(req_a[32*m_grant +: 32], req_b[32*m_grant +: 32]), m_grant, 1'b0});
        m_rr = (m_grant + 1) % N;
      end
    end
    #1;
  endtask

  task automatic set_op(int r, logic [31:0] a, logic [31:0] b);
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
    vt[1] = '{32'hBFC00000, 32'h40000000, 32'hC0400000};
    vt[2] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
    vt[3] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vt[4] = '{32'h3F000000, 32'h40800000, 32'h40000000};
    vt[5] = '{32'hC0000000, 32'hC0400000, 32'h40C00000};
    vt[6] = '{32'h40400000, 32'h40400000, 32'h41100000};
    vt[7] = '{32'h3F800001, 32'h3F800001, 32'h3F800002};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    m_rr = 0; m_ops = 0;
    cycle(1'b0);
    cycle(1'b1);
    rst_n = 1'b1;
    cycle(1'b1);
    chk("reset_busy", 32'(obs_busy), 32'd0);
    chk("reset_ops", 32'(obs_ops), 32'd0);

    // Single op from requester 1.
    set_op(1, 32'h40000000, 32'h40400000); req_valid = 4'b0010;
    cycle(1'b1);
    chk("single_ready", 32'(obs_ready), 32'h2);
    req_valid = '0;
    cycle(1'b1);
    chk("single_lat1", 32'(obs_rv), 32'd0);
    cycle(1'b1);
    chk("single_rv", 32'(obs_rv), 32'd1);
    chk("single_data", obs_data, 32'h40C00000);
    chk("single_id", 32'(obs_id), 32'd1);
    cycle(1'b1);
    chk("single_ops", 32'(obs_ops), 32'd1);

    // Vector table, one op at a time, rotating requesters.
    for (int i = 0; i < 8; i++) begin
      set_op(i % N, vt[i].a, vt[i].b); req_valid = N'(1 << (i % N));
      cycle(1'b1);
      req_valid = '0;
      cycle(1'b1);
      cycle(1'b1);
      chk("vec_data", obs_data, vt[i].p);
      chk("vec_id", 32'(obs_id), 32'(i % N));
    end

    // Round-robin fairness after reset.
    rst_n = 1'b0; cycle(1'b1); rst_n = 1'b1;
    for (int r = 0; r < N; r++) set_op(r, 32'h3F800000 + 32'(r << 20), 32'h40000000);
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1);
      chk("rr_grant", 32'(obs_ready), 32'(1 << (k % N)));
      if (k >= 2) chk("rr_id", 32'(obs_id), 32'((k - 2) % N));
    end
    req_valid = '0;
    repeat (3) cycle(1'b1);

    // Backpressure: two ops held behind rsp_ready = 0.
    rsp_ready = 1'b0;
    set_op(2, 32'hBFC00000, 32'h40000000); req_valid = 4'b0100;
    cycle(1'b1);
    set_op(0, 32'h40400000, 32'h40000000); req_valid = 4'b0001;
    cycle(1'b1);
    set_op(0, 32'h3F800000, 32'h40800000);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1);
      chk("bp_ready", 32'(obs_ready), 32'd0);
      chk("bp_data", obs_data, 32'hC0400000);
      chk("bp_busy", 32'(obs_busy), 32'd1);
    end
    rsp_ready = 1'b1;
    cycle(1'b1);
    chk("bp_resume", 32'(obs_ready), 32'h1);
    req_valid = '0;
    cycle(1'b1);
    chk("bp_second", obs_data, 32'h40C00000);
    repeat (3) cycle(1'b1);

    // Pointer wrap and skip.
    req_valid = 4'b0100;
    cycle(1'b1);
    req_valid = 4'b1001;
    cycle(1'b1);
    chk("wrap_g3", 32'(obs_ready), 32'h8);
    cycle(1'b1);
    chk("wrap_g0", 32'(obs_ready), 32'h1);
    cycle(1'b1);
    chk("wrap_rr1", 32'(obs_ready), 32'h8);
    req_valid = '0;
    repeat (3) cycle(1'b1);

    // Reset with both stages full.
    rsp_ready = 1'b0; req_valid = 4'b0010;
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    chk("mid_full", 32'(obs_ready), 32'd0);
    rst_n = 1'b0;
    cycle(1'b1);
    chk("mid_rst_ready", 32'(obs_ready), 32'd0);
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    cycle(1'b1);
    chk("mid_rv", 32'(obs_rv), 32'd0);
    chk("mid_busy", 32'(obs_busy), 32'd0);
    chk("mid_ops", 32'(obs_ops), 32'd0);
    repeat (2) begin cycle(1'b1); chk("mid_stale", 32'(obs_rv), 32'd0); end
    req_valid = '1;
    cycle(1'b1);
    chk("mid_rr0", 32'(obs_ready), 32'h1);
    req_valid = '0;
    repeat (3) cycle(1'b1);

    // Counter wrap: 17 ops after reset with a 4-bit counter.
    rst_n = 1'b0; cycle(1'b1); rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      set_op(i % N, $urandom, $urandom); req_valid = N'(1 << (i % N));
      cycle(1'b1);
      req_valid = '0;
      cycle(1'b1);
      cycle(1'b1);
    end
    cycle(1'b1);
    chk("cnt_wrap", 32'(obs_ops), 32'd1);

    // Random traffic: requesters hold valid and operands until accepted.
    for (int c = 0; c < 600; c++) begin
      cycle(1'b1);
      rst_n = ($urandom_range(0, 79) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < N; r++) begin
        if ((m_acc && m_grant == r) || !req_valid[r]) begin
          req_valid[r] = ($urandom_range(0, 2) != 0);
          set_op(r, $urandom, $urandom);
        end
      end
    end
    rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    repeat (4) cycle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
